sobol_sequencer: RTL and testbench

Sequencing controller for the combinational Sobol lookup block. On a start command it walks path indices 1..num_paths and, for each path, dimensions 0..M-1. It drives the lookup's path-index and dimension inputs and registers each returned value. It presents the results as a valid/ready stream to the LSM path-generation pipeline, so downstream consumers never address the Sobol block directly.

---
 rtl/sobol_sequencer.sv | 170 +++++++++++++++++
 tb/tb_sobol_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobol_sequencer.sv
// sobol_sequencer
// Walks path indices 1..num_paths and, for each path, dimensions 0..M-1,
// drives the combinational Sobol lookup with the current (path, dim) pair,
// registers the returned value and presents it as a valid/ready stream.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start, abort    : begin a run (sampled in IDLE) / cancel from any state
//   num_paths       : paths in the run, latched when start is accepted
//   busy, done      : not-IDLE flag / one-cycle pulse on normal completion
//   sobol_n/_dim    : address driven to the lookup block
//   sobol_in        : lookup result (combinational in sobol_n/sobol_dim)
//   out_valid/ready : output stream handshake
//   out_data/path/dim/last : stream payload; last marks (num_paths, M-1)
module sobol_sequencer #(
    parameter int M = 50,
    localparam int DW = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [31:0]   num_paths,
    output logic          busy,
    output logic          done,
    output logic [31:0]   sobol_n,
    output logic [DW-1:0] sobol_dim,
    input  logic [31:0]   sobol_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [31:0]   out_path,
    output logic [DW-1:0] out_dim,
    output logic          out_last
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [DW-1:0] DIM_LAST = DW'(M - 1);

    logic [1:0]    state_q, state_d;
    logic [31:0]   num_paths_q, num_paths_d;
    logic [31:0]   path_cnt_q, path_cnt_d;
    logic [DW-1:0] dim_cnt_q, dim_cnt_d;
    logic          done_q, done_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [31:0]   out_data_q, out_data_d;
    logic [31:0]   out_path_q, out_path_d;
    logic [DW-1:0] out_dim_q, out_dim_d;

    logic load_en;
    logic is_final;

    // The output register may be refilled when it is empty or being drained
    // in this very cycle.
    assign load_en  = !out_valid_q || out_ready;
    assign is_final = (path_cnt_q == num_paths_q) && (dim_cnt_q == DIM_LAST);

    always_comb begin
        state_d     = state_q;
        num_paths_d = num_paths_q;
        path_cnt_d  = path_cnt_q;
        dim_cnt_d   = dim_cnt_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_path_d  = out_path_q;
        out_dim_d   = out_dim_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_paths == 32'd0) begin
                        // Empty run: complete immediately, never go busy.
                        done_d = 1'b1;
                    end else begin
                        num_paths_d = num_paths;
                        path_cnt_d  = 32'd1;
                        dim_cnt_d   = '0;
                        state_d     = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (load_en) begin
                    out_data_d  = sobol_in;
                    out_path_d  = path_cnt_q;
                    out_dim_d   = dim_cnt_q;
                    out_valid_d = 1'b1;
                    out_last_d  = is_final;
                    if (is_final) begin
                        // Counters keep addressing the final element.
                        state_d = ST_DRAIN;
                    end else if (dim_cnt_q == DIM_LAST) begin
                        // Wrap at M-1, not at the power of two.
                        dim_cnt_d  = '0;
                        path_cnt_d = path_cnt_q + 32'd1;
                    end else begin
                        dim_cnt_d = dim_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    path_cnt_d  = '0;
                    dim_cnt_d   = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Cancel overrides start and any handshake in the same cycle; the
        // word on the bus this cycle is treated as never transferred.
        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            path_cnt_d  = '0;
            dim_cnt_d   = '0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_paths_q <= '0;
            path_cnt_q  <= '0;
            dim_cnt_q   <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_path_q  <= '0;
            out_dim_q   <= '0;
        end else begin
            state_q     <= state_d;
            num_paths_q <= num_paths_d;
            path_cnt_q  <= path_cnt_d;
            dim_cnt_q   <= dim_cnt_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_path_q  <= out_path_d;
            out_dim_q   <= out_dim_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign sobol_n   = (state_q == ST_IDLE) ? 32'd0 : path_cnt_q;
    assign sobol_dim = (state_q == ST_IDLE) ? '0 : dim_cnt_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_path  = out_path_q;
    assign out_dim   = out_dim_q;

endmodule

// File: tb/tb_sobol_sequencer.sv
// Bench for sobol_sequencer: an M=2 instance checked every cycle against a
// word-queue model, and an M=50 instance exercised with a two-path run.
module tb_sobol_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Stand-in lookup block: dim 0 is the van der Corput sequence (bit
    // reversal of n), other dims an arbitrary hash of (n, d).
    function automatic logic [31:0] lookup(input logic [31:0] n, input int d);
        logic [31:0] r;
        r = '0;
        if (d == 0) begin
            for (int i = 0; i < 32; i++) r[i] = n[31-i];
        end else begin
            r = (n * 32'h9E3779B9) ^ (32'(d) * 32'h85EBCA6B) ^ 32'h5A5A0F0F;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected completion (cycle %0d)", name, cyc);
    endtask

    // ---------------- DUT A: M = 2 ----------------
    logic        rst;
    logic        a_start, a_abort, a_ready;
    logic [31:0] a_num;
    logic        a_busy, a_done, a_valid, a_last;
    logic [31:0] a_sn, a_sin, a_data, a_path;
    logic [0:0]  a_sd, a_dim;

    assign a_sin = lookup(a_sn, int'(a_sd));

    sobol_sequencer #(.M(2)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .num_paths(a_num),
        .busy(a_busy), .done(a_done), .sobol_n(a_sn), .sobol_dim(a_sd), .sobol_in(a_sin),
        .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data), .out_path(a_path),
        .out_dim(a_dim), .out_last(a_last)
    );

    // ---------------- DUT B: M = 50 ----------------
    logic        b_start, b_abort, b_ready;
    logic [31:0] b_num;
    logic        b_busy, b_done, b_valid, b_last;
    logic [31:0] b_sn, b_sin, b_data, b_path;
    logic [5:0]  b_sd, b_dim;

    assign b_sin = lookup(b_sn, int'(b_sd));

    sobol_sequencer #(.M(50)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .num_paths(b_num),
        .busy(b_busy), .done(b_done), .sobol_n(b_sn), .sobol_dim(b_sd), .sobol_in(b_sin),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data), .out_path(b_path),
        .out_dim(b_dim), .out_last(b_last)
    );

    // ---------------- behavioural model of DUT A ----------------
    typedef struct {
        logic [31:0] path;
        int          dim;
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t exp_q[$];
    word_t cap_q[$];
    bit    mon_en   = 0;
    bit    active   = 0;   // a run is in progress (busy expected)
    int    age      = 0;   // cycles since the run became active
    bit    done_exp = 0;
    bit    hold_prev = 0;
    word_t prev;

    always @(negedge clk) begin
        if (mon_en) begin
            word_t w;
            word_t e;
            bit    hs;
            bit    done_next;
            chkb("busy", a_busy, active);
            chkb("done", a_done, done_exp);
            if (!active) begin
                chkb("idle_valid", a_valid, 1'b0);
                chk("idle_sobol_n", a_sn, 32'd0);
            end else if (age == 0) begin
                chkb("valid_latency_c1", a_valid, 1'b0);
            end else if (age == 1) begin
                chkb("valid_latency_c2", a_valid, 1'b1);
            end
            if (hold_prev) begin
                chkb("stall_valid", a_valid, 1'b1);
                chk("stall_data", a_data, prev.data);
                chk("stall_path", a_path, prev.path);
                chk("stall_dim", 32'(a_dim), 32'(prev.dim));
                chkb("stall_last", a_last, prev.last);
            end
            hs = a_valid && a_ready && !a_abort && !rst;
            if (hs) begin
                w.path = a_path; w.dim = int'(a_dim); w.data = a_data; w.last = a_last;
                $display("A word path=%0d dim=%0d data=%h last=%0b", w.path, w.dim, w.data, w.last);
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_path", w.path, e.path);
                    chk("word_dim", 32'(w.dim), 32'(e.dim));
                    chk("word_data", w.data, e.data);
                    chkb("word_last", w.last, e.last);
                end
                cap_q.push_back(w);
            end
            hold_prev = a_valid && !a_ready && !a_abort && !rst;
            prev.path = a_path; prev.dim = int'(a_dim); prev.data = a_data; prev.last = a_last;

            done_next = 0;
            if (rst || a_abort) begin
                active = 0;
                exp_q.delete();
            end else if (active) begin
                if (hs && exp_q.size() == 0) begin
                    active = 0;
                    done_next = 1;
                end else begin
                    age++;
                end
            end else if (a_start) begin
                if (a_num == 32'd0) begin
                    done_next = 1;
                end else begin
                    active = 1;
                    age = 0;
                    for (int p = 1; p <= int'(a_num); p++) begin
                        for (int d = 0; d < 2; d++) begin
                            word_t x;
                            x.path = 32'(p); x.dim = d; x.data = lookup(32'(p), d);
                            x.last = (p == int'(a_num)) && (d == 1);
                            exp_q.push_back(x);
                        end
                    end
                end
            end
            done_exp = done_next;
        end
    end

    // mode 0: ready=1; 1: ready pattern 1,0,0,1; 2: random ready/start noise/abort;
    // 3: ready=1, abort once 3 words have transferred
    task automatic run_a(input logic [31:0] num, input int mode);
        bit fin = 0;
        bit ab  = 0;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        a_start = 1'b1; a_num = num; a_abort = 1'b0; a_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (a_done || ab) begin
                fin = 1;
                break;
            end
            @(posedge clk); #1;
            a_start = 1'b0;
            case (mode)
                1: a_ready = pat[(i + 1) % 4];
                2: begin
                    a_ready = 1'($urandom_range(0, 1));
                    if (num != 0 && $urandom_range(0, 5) == 0) begin
                        a_start = 1'b1;
                        a_num = 32'($urandom_range(0, 9));
                    end
                    if (num != 0 && $urandom_range(0, 49) == 0) begin
                        a_abort = 1'b1;
                        ab = 1;
                    end
                end
                3: if (cap_q.size() == 3 && !ab) begin
                    a_abort = 1'b1;
                    ab = 1;
                end
                default: a_ready = 1'b1;
            endcase
        end
        if (!fin) fail_now("run_a_timeout");
    endtask

    task automatic drain_a();
        int idle_cnt = 0;
        @(posedge clk); #1;
        a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!a_busy) idle_cnt++; else idle_cnt = 0;
            if (idle_cnt >= 2) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_a();
        chkb("rst_busy", a_busy, 1'b0);
        chkb("rst_done", a_done, 1'b0);
        chkb("rst_valid", a_valid, 1'b0);
        chkb("rst_last", a_last, 1'b0);
        chk("rst_data", a_data, 32'd0);
        chk("rst_path", a_path, 32'd0);
        chk("rst_dim", 32'(a_dim), 32'd0);
        chk("rst_sobol_n", a_sn, 32'd0);
        chk("rst_sobol_dim", 32'(a_sd), 32'd0);
    endtask

    initial begin
        int first_v, last_hs, done_c, start_c, nw, ep, ed;
        rst = 1'b1;
        a_start = 0; a_abort = 0; a_ready = 1; a_num = 0;
        b_start = 0; b_abort = 0; b_ready = 1; b_num = 0;
        @(posedge clk); #1;
        mon_en = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_a();
        chkb("rst_b_valid", b_valid, 1'b0);
        chkb("rst_b_busy", b_busy, 1'b0);
        @(posedge clk); #1;

        // 1: num_paths=3, ready high: literal stream pins
        cap_q.delete();
        run_a(32'd3, 0);
        chk("s1_count", 32'(cap_q.size()), 32'd6);
        if (cap_q.size() == 6) begin
            chk("s1_w0", cap_q[0].data, 32'h80000000);
            chk("s1_w2", cap_q[2].data, 32'h40000000);
            chk("s1_w4", cap_q[4].data, 32'hC0000000);
            chk("s1_w5_path", cap_q[5].path, 32'd3);
            chkb("s1_w4_last", cap_q[4].last, 1'b0);
            chkb("s1_w5_last", cap_q[5].last, 1'b1);
        end
        drain_a();

        // 2: same run with ready toggling 1,0,0,1
        cap_q.delete();
        run_a(32'd3, 1);
        chk("s2_count", 32'(cap_q.size()), 32'd6);
        if (cap_q.size() == 6) chk("s2_w4", cap_q[4].data, 32'hC0000000);
        drain_a();

        // 3: num_paths=0
        cap_q.delete();
        run_a(32'd0, 0);
        chk("s3_count", 32'(cap_q.size()), 32'd0);
        drain_a();

        // 4: abort after 3 words, then a one-path run
        cap_q.delete();
        run_a(32'd3, 3);
        drain_a();
        chk("s4_count", 32'(cap_q.size()), 32'd3);
        cap_q.delete();
        run_a(32'd1, 0);
        chk("s4_restart_count", 32'(cap_q.size()), 32'd2);
        if (cap_q.size() == 2) begin
            chk("s4_restart_path", cap_q[0].path, 32'd1);
            chk("s4_restart_dim", 32'(cap_q[0].dim), 32'd0);
        end
        drain_a();

        // 5: stall in DRAIN, ignored start, then reset
        cap_q.delete();
        a_start = 1'b1; a_num = 32'd2; a_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            a_start = 1'b0;
            if (cap_q.size() >= 3) break;
        end
        a_ready = 1'b0;
        @(posedge clk); #1;
        a_start = 1'b1; a_num = 32'd9;
        @(posedge clk); #1;
        a_start = 1'b0;
        @(negedge clk);
        chkb("s5_drain_valid", a_valid, 1'b1);
        chkb("s5_drain_last", a_last, 1'b1);
        chk("s5_drain_path", a_path, 32'd2);
        chk("s5_drain_sobol_n", a_sn, 32'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_a();
        drain_a();

        // 6: randomized runs
        for (int r = 0; r < 8; r++) begin
            run_a(32'($urandom_range(0, 5)), 2);
            drain_a();
        end

        // 7: M=50, two paths, ready high
        b_start = 1'b1; b_num = 32'd2; b_ready = 1'b1;
        start_c = cyc; first_v = -1; last_hs = -1; done_c = -1; nw = 0; ep = 1; ed = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (b_done) begin
                done_c = cyc;
                break;
            end
            if (b_valid) begin
                $display("B word path=%0d dim=%0d data=%h last=%0b", b_path, b_dim, b_data, b_last);
                if (first_v < 0) first_v = cyc;
                last_hs = cyc;
                chk("b_path", b_path, 32'(ep));
                chk("b_dim", 32'(b_dim), 32'(ed));
                chk("b_data", b_data, lookup(32'(ep), ed));
                chkb("b_last", b_last, nw == 99);
                nw++;
                if (ed == 49) begin ed = 0; ep++; end else ed++;
            end
            @(posedge clk); #1;
            b_start = 1'b0;
        end
        if (done_c < 0) fail_now("b_done_timeout");
        chk("b_words", 32'(nw), 32'd100);
        chk("b_first_latency", 32'(first_v - start_c), 32'd2);
        chk("b_stream_span", 32'(last_hs - first_v), 32'd99);
        chk("b_done_after_last", 32'(done_c - last_hs), 32'd1);
        chkb("b_busy_at_done", b_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
